// File: rtl/seq_bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for seq_bit_serializer.
//   din        word from the producer
//   din_valid  din holds a word
//   din_ready  serializer takes the word at the next posedge
//   ser_en     consumer takes the current serial bit this cycle
//   dout       current serial bit
//   dout_valid dout is a data bit consumed this cycle
//   word_start dout is the first bit of a word
//   busy       a word is loaded in the shifter
// master: producer/consumer side; slave: the serializer.
`timescale 1ns/1ps
interface seq_bit_serializer_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              ser_en;
   logic              dout;
   logic              dout_valid;
   logic              word_start;
   logic              busy;

   modport master (
      output din, din_valid, ser_en,
      input  din_ready, dout, dout_valid, word_start, busy
   );

   modport slave (
      input  din, din_valid, ser_en,
      output din_ready, dout, dout_valid, word_start, busy
   );
endinterface

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the 1011 sequence detector.
// Takes DATA_W-bit words over a valid/ready handshake and shifts them out one
// bit per cycle. A one-word holding buffer lets the next word follow the last
// bit of the current one with no gap; ser_en stalls the stream without losing
// or repeating bits.
// Ports:
//   clk  posedge clock
//   rst  synchronous active-high reset
//   bus  seq_bit_serializer_if.slave (din/din_valid/din_ready in, ser_en in,
//        dout/dout_valid/word_start/busy out); its DATA_W must match DATA_W here.
`timescale 1ns/1ps
module seq_bit_serializer #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   seq_bit_serializer_if.slave bus
);

   localparam int unsigned       CntW    = $clog2(DATA_W);
   localparam logic [CntW-1:0]   LastCnt = CntW'(DATA_W - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] hold_q;
   logic              hold_vld_q;

   logic [DATA_W-1:0] din_ord;
   logic              accept;
   logic              last_bit;

   // Words are stored in send order so the outgoing bit is always sr_q[DATA_W-1].
   for (genvar i = 0; i < DATA_W; i++) begin : g_ord
      assign din_ord[i] = bus.din[MSB_FIRST ? i : DATA_W - 1 - i];
   end

   assign bus.din_ready  = !rst && !hold_vld_q;
   assign bus.busy       = (state_q == StShift);
   assign bus.dout_valid = bus.busy && bus.ser_en;
   assign bus.word_start = bus.dout_valid && (cnt_q == '0);
   assign bus.dout       = bus.busy ? sr_q[DATA_W-1] : IDLE_BIT;

   assign accept   = bus.din_valid && bus.din_ready;
   assign last_bit = bus.dout_valid && (cnt_q == LastCnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sr_q       <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  sr_q    <= din_ord;
                  cnt_q   <= '0;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (bus.ser_en) begin
                  if (cnt_q != LastCnt) begin
                     sr_q  <= {sr_q[DATA_W-2:0], 1'b0};
                     cnt_q <= cnt_q + 1'b1;
                  end else if (hold_vld_q) begin
                     sr_q       <= hold_q;
                     hold_vld_q <= 1'b0;
                     cnt_q      <= '0;
                  end else if (accept) begin
                     // Bypass the holding buffer so the new word follows gaplessly.
                     sr_q  <= din_ord;
                     cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               // accept implies hold is empty, so this never collides with the
               // hold-to-shifter transfer above.
               if (accept && !last_bit) begin
                  hold_q     <= din_ord;
                  hold_vld_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
